// File: rtl/counter_slot_arbiter.sv
// counter_slot_arbiter: round-robin grant of one shared up-counter to NUM_REQ clients.
// Optional feature macro: COUNTER_SLOT_ABORT_EN (owner dropping req aborts its slot).
module counter_slot_arbiter #(
  parameter int CNT_WIDTH = 3,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*CNT_WIDTH-1:0] term_val,
  output logic [NUM_REQ-1:0]           grant,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         counter,
  output logic [NUM_REQ-1:0]           done
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   grant_reg, done_reg, winner_onehot;
  logic [ID_W-1:0]      grant_id_reg, ptr_reg, winner, ptr_next;
  logic [CNT_WIDTH-1:0] counter_reg, term_reg;
  logic [CNT_WIDTH-1:0] term_slice [NUM_REQ];
  logic [ID_W:0]        idx;
  logic                 found, abort, at_term;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign term_slice[gi]    = term_val[gi*CNT_WIDTH +: CNT_WIDTH];
      assign winner_onehot[gi] = (winner == ID_W'(gi));
    end
  endgenerate

  // First set request at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_reg} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

`ifdef COUNTER_SLOT_ABORT_EN
  assign abort = ~req[grant_id_reg];
`else
  assign abort = 1'b0;
`endif

  assign at_term  = (counter_reg == term_reg);
  assign ptr_next = (grant_id_reg == ID_W'(NUM_REQ-1)) ? '0 : grant_id_reg + ID_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (found) state_next = S_COUNT;
      S_COUNT: if (abort || at_term) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != S_IDLE);
  end

  // Abort wins over a terminal match in the same cycle and leaves done low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_reg    <= '0;
      grant_id_reg <= '0;
      counter_reg  <= '0;
      term_reg     <= '0;
      done_reg     <= '0;
      ptr_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (found) begin
            grant_reg    <= winner_onehot;
            grant_id_reg <= winner;
            term_reg     <= term_slice[winner];
            counter_reg  <= '0;
          end
        end
        S_COUNT: begin
          if (abort) begin
            grant_reg   <= '0;
            counter_reg <= '0;
          end else if (at_term) begin
            done_reg  <= grant_reg;
            grant_reg <= '0;
          end else begin
            counter_reg <= counter_reg + CNT_WIDTH'(1);
          end
        end
        S_DONE: begin
          done_reg <= '0;
          ptr_reg  <= ptr_next;
        end
        default: ;
      endcase
    end
  end

  assign grant    = grant_reg;
  assign grant_id = grant_id_reg;
  assign counter  = counter_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_counter_slot_arbiter.sv
// Scoreboard bench for counter_slot_arbiter: a timeline model predicts every cycle's outputs.
// Follows COUNTER_SLOT_ABORT_EN the same way the design does.
module tb_counter_slot_arbiter;
  localparam int CW = 3;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req = '1;
  logic [NR*CW-1:0] term_val = '0;
  logic [NR-1:0]    grant, done;
  logic [IW-1:0]    grant_id;
  logic             busy;
  logic [CW-1:0]    counter;

  counter_slot_arbiter #(.CNT_WIDTH(CW), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset), .req(req), .term_val(term_val),
    .grant(grant), .grant_id(grant_id), .busy(busy), .counter(counter), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] grant;
    logic [IW-1:0] gid;
    logic          busy;
    logic [CW-1:0] cnt;
    logic [NR-1:0] done;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int passes = 0;

  // Slot timeline: granted at edge g, match/abort edge e, back to idle after edge e+1.
  bit            m_have, m_abort;
  int            m_n, m_g, m_e, m_ptr, m_id;
  logic [CW-1:0] m_term, m_last_cnt;
  logic [IW-1:0] m_last_id;

  localparam logic [NR*CW-1:0] T_ALL1 = {NR{3'd1}};

  task automatic model_reset();
    m_have = 0; m_abort = 0; m_ptr = 0; m_id = 0;
    m_last_cnt = '0; m_last_id = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    snap_t s;
    bit    hit;
    m_n++;
    if (!m_have || m_n >= m_e + 2) begin
      if (req != '0) begin
        hit = 0;
        for (int k = 0; k < NR; k++) begin
          int c;
          c = (m_ptr + k) % NR;
          if (!hit && req[c]) begin hit = 1; m_id = c; end
        end
        m_have = 1; m_abort = 0; m_g = m_n;
        m_term = term_val[m_id*CW +: CW];
        m_e = m_n + 1 + int'(m_term);
        m_ptr = (m_id + 1) % NR;
        m_last_id = IW'(m_id);
      end
    end else if (m_n > m_g && m_n <= m_e) begin
`ifdef COUNTER_SLOT_ABORT_EN
      if (!req[m_id]) begin m_e = m_n; m_abort = 1; end
`endif
    end
    s.grant = '0; s.done = '0; s.busy = 1'b0;
    s.gid = m_last_id; s.cnt = m_last_cnt;
    if (m_have && m_n >= m_g && m_n < m_e) begin
      s.grant[m_id] = 1'b1; s.busy = 1'b1; s.cnt = CW'(m_n - m_g);
    end else if (m_have && m_n == m_e) begin
      s.busy = 1'b1;
      if (!m_abort) s.done[m_id] = 1'b1;
      s.cnt = m_abort ? '0 : m_term;
      m_last_cnt = s.cnt;
    end
    exp_q.push_back(s);
  endtask

  task automatic drive_step(input logic [NR-1:0] r, input logic [NR*CW-1:0] tv);
    req = r; term_val = tv;
    model_step();
  endtask

  task automatic run(input logic [NR-1:0] r, input logic [NR*CW-1:0] tv, input int n);
    repeat (n) begin
      @(negedge clk);
      drive_step(r, tv);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(posedge clk) begin
    snap_t s;
    #1;
    if (!reset) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow: DUT cycle with no expectation queued");
      end else begin
        s = exp_q.pop_front();
        if (grant === s.grant && grant_id === s.gid && busy === s.busy &&
            counter === s.cnt && done === s.done) begin
          passes++;
          if (s.busy && s.grant == '0)
            $display("slot end: owner %0d done=%b counter=%0d", s.gid, done, counter);
        end else begin
          $display("FAIL cycle_outputs: got grant=%b id=%0d busy=%b cnt=%0d done=%b expected grant=%b id=%0d busy=%b cnt=%0d done=%b",
                   grant, grant_id, busy, counter, done, s.grant, s.gid, s.busy, s.cnt, s.done);
        end
      end
    end
  end

  initial begin
    m_n = 0;
    model_reset();
    // Reset held with every request active
    repeat (2) @(negedge clk);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_counter", 32'(counter), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_grant_id", 32'(grant_id), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive_step(4'b1111, T_ALL1);
    run(4'b1111, T_ALL1, 3);
    run(4'b0000, T_ALL1, 8);
    // Single requester 2, term 3
    run(4'b0100, 12'h0C0, 6);
    run(4'b0000, 12'h0C0, 8);
    // Round-robin between 0 and 3 with wrap
    run(4'b1001, T_ALL1, 16);
    run(4'b0000, T_ALL1, 8);
    // Zero-length slot for requester 1
    run(4'b0010, 12'h000, 3);
    run(4'b0000, 12'h000, 6);
    // Requester 1 term 7 drops req at counter 2; requester 2 (term 2) waits
    run(4'b0010, 12'h0B8, 3);
    run(4'b0100, 12'h0B8, 14);
    run(4'b0000, 12'h0B8, 8);
    // Asynchronous reset in the middle of a slot
    run(4'b0001, 12'h007, 6);
    @(negedge clk);
    chk("pre_reset_counter", 32'(counter), 32'd5);
    reset = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_counter", 32'(counter), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive_step(4'b1111, T_ALL1);
    run(4'b1111, T_ALL1, 4);
    run(4'b0000, T_ALL1, 8);
    // Random traffic with sticky requests and term_val changing underneath
    begin
      logic [NR-1:0]    r;
      logic [NR*CW-1:0] tv;
      r = 4'b0101;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 3) == 0) r = NR'($urandom_range(0, 15));
        tv = (NR*CW)'($urandom());
        run(r, tv, 1);
      end
    end
    run(4'b0000, 12'h000, 14);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/counter_slot_arbiter.md
# counter_slot_arbiter

Round-robin arbiter and sequencer for a single shared n-bit up-counter. Up to `NUM_REQ` requesters each ask for a timed slot of programmable length. The block grants one requester at a time, runs the counter from 0 to that requester's terminal value, then signals completion. It sits between client control FSMs and the shared counter resource, replacing per-client free-running counters.

## Interface
- `CNT_WIDTH`, 3: width of the shared counter and of each terminal value.
- `NUM_REQ`, 4: number of requesters; legal values are 2 to 16.
- `ID_W`, `$clog2(NUM_REQ)`: width of `grant_id`.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset that clears all state immediately.
- `req`  in  `NUM_REQ`: level request per requester; bit i belongs to requester i.
- `term_val`  in  `NUM_REQ*CNT_WIDTH`: terminal count for requester i in bits `[i*CNT_WIDTH +: CNT_WIDTH]`.
- `grant`  out  `NUM_REQ`: one-hot; requester currently owning the counter; registered.
- `grant_id`  out  `ID_W`: binary index of the current/last owner; registered.
- `busy`  out  1: high whenever the state is not IDLE.
- `counter`  out  `CNT_WIDTH`: shared counter value.
- `done`  out  `NUM_REQ`: one-cycle pulse on the owner's bit when its slot completes.

## Operation
- States: IDLE, COUNT, DONE. Internal registers: `ptr` (priority pointer, `ID_W` bits) and `term` (latched terminal value).
- Reset values: state IDLE; `grant`=0, `grant_id`=0, `busy`=0, `counter`=0, `done`=0, `ptr`=0, `term`=0.
- IDLE:
  - If `req` is nonzero, pick the winner as the first set bit searching `ptr`, `ptr+1`, … with wrap modulo `NUM_REQ`.
  - On the edge: `grant`←onehot(winner), `grant_id`←winner, `term`←winner's `term_val` slice, `counter`←0, state←COUNT.
  - If `req` is zero, nothing changes.
- COUNT:
  - If `counter`≠`term`: `counter`←`counter`+1.
  - If `counter`==`term`: `done[winner]`←1, `grant`←0, state←DONE. `counter` holds its value.
- DONE: `done`←0, `ptr`←(`grant_id`+1) mod `NUM_REQ`, state←IDLE.
- `term_val` is sampled only at grant. Changing it mid-slot has no effect.
- `term`=0 gives exactly one COUNT cycle.
- The counter never wraps, because `term` ≤ 2^`CNT_WIDTH`−1.
- `req` of other requesters is ignored outside IDLE.
- Asserting `reset` mid-slot clears everything asynchronously. No `done` is emitted for the interrupted slot.

## Timing
- Latency from IDLE with `req` seen at edge E: `grant` is high from E+1, and `counter`=0 in cycle E+1.
- `counter` equals k in cycle E+1+k. `done` is high in cycle E+2+`term`, the same cycle `grant` drops.
- Back in IDLE at cycle E+3+`term`. The earliest next grant is E+4+`term`.
- Slot period for continuously requesting clients is `term`+3 cycles.
- `done` and `grant` are never high for the same requester in the same cycle.
- `grant` is zero or one-hot at all times.

## Configuration
- `COUNTER_SLOT_ABORT_EN` defined:
  - In COUNT, if `req[grant_id]` is 0, the slot aborts on the next edge: `grant`←0, `counter`←0, `done` stays 0, state←DONE (`ptr` advances as normal).
  - Abort takes priority over terminal match in the same cycle.
- Not defined: `req` is ignored after grant, and every slot runs to its terminal count.

## Test plan
- Reset sequence: hold `reset`=1 for 2 cycles with `req`=4'b1111 -> all outputs 0 and `busy`=0. After release, `grant`=4'b0001 on the first edge.
- Single requester: `req`=4'b0100, slice 2 `term_val`=3 -> `grant`=4'b0100 for 4 cycles with `counter` 0,1,2,3. Then `done`=4'b0100 for 1 cycle, then `busy` low.
- Round-robin with wrap: `req`=4'b1001 held, all terms=1 -> grant order 0,3,0,3. Successive grants are 4 cycles apart. `ptr` wraps from 3 to 0.
- Zero-length slot: `term_val` slice=0 -> one COUNT cycle with `counter`=0, `done` on the next cycle. Total slot is 3 cycles.
- Abort (macro defined): requester 1 with term=7; drop `req[1]` when `counter`=2 -> `grant` clears next edge, `done` never pulses, requester 2 gets granted afterwards. With the macro undefined, the slot runs to 7 and `done` pulses.
- Reset mid-slot: assert `reset` asynchronously at `counter`=5 -> `grant`, `counter` and `busy` go to 0 immediately, no `done` is emitted, and `ptr` returns to 0.
